pd_decode: RTL and testbench

// - Fetch-to-decode stage: accepts {pc, insn} from the fetch stage, decodes RV32I fields and

---
 rtl/pd_pkg.sv | 38 +++
 rtl/pd_imm_gen.sv | 40 ++++
 rtl/pd_decode.sv | 133 +++++++++++++
 tb/tb_pd_decode.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types and opcode constants for the fetch-to-decode stage.
package pd_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/pd_imm_gen.sv
// Combinational RV32I immediate generator and major-opcode legality check.
module pd_imm_gen
  import pd_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  imm_fmt_e fmt;

  always_comb begin
    fmt       = IMM_NONE;
    illegal_o = 1'b0;
    case (insn_i[6:0])
      OP_LOAD, OP_OP_IMM, OP_JALR:       fmt = IMM_I;
      OP_STORE:                          fmt = IMM_S;
      OP_BRANCH:                         fmt = IMM_B;
      OP_LUI, OP_AUIPC:                  fmt = IMM_U;
      OP_JAL:                            fmt = IMM_J;
      OP_OP, OP_MISC_MEM, OP_SYSTEM:     fmt = IMM_NONE;
      default:                           illegal_o = 1'b1;
    endcase
    // Compressed encodings are not supported; every legal opcode already ends in 2'b11.
    if (insn_i[1:0] != 2'b11) illegal_o = 1'b1;
  end

  always_comb begin
    imm_o = '0;
    case (fmt)
      IMM_I: imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
      IMM_S: imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      IMM_B: imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      IMM_U: imm_o = {insn_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/pd_decode.sv
// Fetch-to-decode stage: decodes on the input side into a 2-entry (output + skid) buffer
// so that f_ready is registered and downstream stalls never reach fetch combinationally.
module pd_decode
  import pd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h01000000,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [XLEN-1:0] f_pc,
  input  logic [XLEN-1:0] f_insn,
  input  logic            flush,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_insn,
  output logic [6:0]      d_opcode,
  output logic [4:0]      d_rd,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [2:0]      d_funct3,
  output logic [6:0]      d_funct7,
  output logic [XLEN-1:0] d_imm,
  output logic            d_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  state_e      state_q, state_d;
  logic        d_valid_q, f_ready_q;
  entry_t      out_q, skid_q, in_e;
  logic [31:0] in_imm;
  logic        in_illegal;
  logic        accept, consume;
  logic        load_out, load_skid, out_from_skid;

  pd_imm_gen u_imm_gen (
    .insn_i    (f_insn),
    .imm_o     (in_imm),
    .illegal_o (in_illegal)
  );

  always_comb begin
    in_e.pc      = f_pc;
    in_e.insn    = f_insn;
    in_e.opcode  = f_insn[6:0];
    in_e.rd      = f_insn[11:7];
    in_e.rs1     = f_insn[19:15];
    in_e.rs2     = f_insn[24:20];
    in_e.funct3  = f_insn[14:12];
    in_e.funct7  = f_insn[31:25];
    in_e.imm     = in_imm;
    in_e.illegal = in_illegal;
  end

  assign accept  = f_valid & f_ready_q;
  assign consume = d_valid_q & d_ready;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      // Redirect: held entries and the same-cycle input are discarded.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_out = 1'b1;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !consume) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (!accept && consume) begin
            state_d = ST_EMPTY;
          end else if (accept && consume) begin
            load_out = 1'b1;
          end
        end
        ST_TWO: begin
          if (consume) begin
            out_from_skid = 1'b1;
            state_d       = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      d_valid_q <= 1'b0;
      f_ready_q <= 1'b0;
      out_q     <= '0;
      out_q.pc  <= RESET_PC;
    end else begin
      state_q   <= state_d;
      d_valid_q <= (state_d != ST_EMPTY);
      f_ready_q <= (state_d != ST_TWO);
      if (load_out)           out_q <= in_e;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= in_e;
    end
  end

  assign f_ready   = f_ready_q;
  assign d_valid   = d_valid_q;
  assign d_pc      = out_q.pc;
  assign d_insn    = out_q.insn;
  assign d_opcode  = out_q.opcode;
  assign d_rd      = out_q.rd;
  assign d_rs1     = out_q.rs1;
  assign d_rs2     = out_q.rs2;
  assign d_funct3  = out_q.funct3;
  assign d_funct7  = out_q.funct7;
  assign d_imm     = out_q.imm;
  assign d_illegal = out_q.illegal;

endmodule

// File: tb/tb_pd_decode.sv
// Directed bench for pd_decode: queue-based reference model checked every cycle, plus literal checks.
module tb_pd_decode;

  localparam logic [31:0] RESET_PC = 32'h01000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        f_valid = 1'b0;
  logic        f_ready;
  logic [31:0] f_pc = '0;
  logic [31:0] f_insn = '0;
  logic        flush = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [31:0] d_pc, d_insn, d_imm;
  logic [6:0]  d_opcode, d_funct7;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [2:0]  d_funct3;
  logic        d_illegal;

  pd_decode #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_pc      (f_pc),
    .f_insn    (f_insn),
    .flush     (flush),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_pc      (d_pc),
    .d_insn    (d_insn),
    .d_opcode  (d_opcode),
    .d_rd      (d_rd),
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .d_funct3  (d_funct3),
    .d_funct7  (d_funct7),
    .d_imm     (d_imm),
    .d_illegal (d_illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t decode(input logic [31:0] pc, input logic [31:0] insn);
    exp_t e;
    logic [6:0] legal [11];
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic [6:0] op;
    legal = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
              7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    op = insn[6:0];
    e.pc = pc;
    e.insn = insn;
    e.illegal = 1'b1;
    for (int k = 0; k < 11; k++) if (op == legal[k]) e.illegal = 1'b0;
    if (insn[1:0] != 2'b11) e.illegal = 1'b1;
    e.imm = 32'd0;
    if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111) begin
      i12 = insn[31:20];
      e.imm = 32'(i12);
    end else if (op == 7'b0100011) begin
      i12 = {insn[31:25], insn[11:7]};
      e.imm = 32'(i12);
    end else if (op == 7'b1100011) begin
      b13 = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      e.imm = 32'(b13);
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      e.imm = insn & 32'hFFFFF000;
    end else if (op == 7'b1101111) begin
      j21 = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      e.imm = 32'(j21);
    end
    return e;
  endfunction

  // Reference model: a FIFO of at most two decoded entries.
  exp_t        q[$];
  logic        ready_m = 1'b0;
  logic        started = 1'b0;
  logic [31:0] last_pc = RESET_PC;
  logic [31:0] last_insn = '0;
  logic [31:0] dlog[$];

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      ready_m   = 1'b0;
      last_pc   = RESET_PC;
      last_insn = '0;
      started   = 1'b1;
    end else begin
      logic acc, con;
      if (d_valid && d_ready) dlog.push_back(d_pc);
      acc = f_valid && ready_m;
      con = (q.size() > 0) && d_ready;
      if (q.size() > 0) begin
        last_pc   = q[0].pc;
        last_insn = q[0].insn;
      end
      if (con) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(decode(f_pc, f_insn));
      ready_m = (q.size() < 2);
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("f_ready", {31'd0, f_ready}, {31'd0, ready_m});
      chk("d_valid", {31'd0, d_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("d_pc", d_pc, q[0].pc);
        chk("d_insn", d_insn, q[0].insn);
        chk("d_opcode", {25'd0, d_opcode}, {25'd0, q[0].insn[6:0]});
        chk("d_rd", {27'd0, d_rd}, {27'd0, q[0].insn[11:7]});
        chk("d_rs1", {27'd0, d_rs1}, {27'd0, q[0].insn[19:15]});
        chk("d_rs2", {27'd0, d_rs2}, {27'd0, q[0].insn[24:20]});
        chk("d_funct3", {29'd0, d_funct3}, {29'd0, q[0].insn[14:12]});
        chk("d_funct7", {25'd0, d_funct7}, {25'd0, q[0].insn[31:25]});
        chk("d_imm", d_imm, q[0].imm);
        chk("d_illegal", {31'd0, d_illegal}, {31'd0, q[0].illegal});
      end else begin
        chk("d_pc_hold", d_pc, last_pc);
        chk("d_insn_hold", d_insn, last_insn);
      end
    end
  end

  logic [31:0] imm_insn [5] = '{32'hFFC10113, 32'h00112623, 32'hFE000EE3, 32'h123450B7, 32'h0080006F};
  logic [31:0] imm_exp  [5] = '{32'hFFFFFFFC, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};
  logic [31:0] ill_insn [2] = '{32'h00000000, 32'hFFFFFFFF};

  initial begin
    int beats;
    int rdy_hi;
    repeat (3) @(negedge clock);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_d_pc", d_pc, RESET_PC);
    chk("rst_d_insn", d_insn, 32'd0);
    chk("rst_d_imm", d_imm, 32'd0);
    chk("rst_f_ready", {31'd0, f_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_f_ready", {31'd0, f_ready}, 32'd1);

    // addi x1, x0, 5
    d_ready = 1'b1;
    f_valid = 1'b1; f_pc = 32'h01000000; f_insn = 32'h00500093;
    @(negedge clock);
    chk("addi_valid", {31'd0, d_valid}, 32'd1);
    chk("addi_pc", d_pc, 32'h01000000);
    chk("addi_rd", {27'd0, d_rd}, 32'd1);
    chk("addi_rs1", {27'd0, d_rs1}, 32'd0);
    chk("addi_funct3", {29'd0, d_funct3}, 32'd0);
    chk("addi_imm", d_imm, 32'd5);
    chk("addi_illegal", {31'd0, d_illegal}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      f_pc = 32'h01000004 + 32'(i * 4); f_insn = imm_insn[i];
      @(negedge clock);
      chk("imm_literal", d_imm, imm_exp[i]);
    end
    f_valid = 1'b0;
    @(negedge clock);

    // Back-pressure: 0x0, 0x4, 0x8 with execute stalled.
    dlog.delete();
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h0; f_insn = 32'h00000013;
    @(negedge clock);
    chk("bp_one_valid", {31'd0, d_valid}, 32'd1);
    chk("bp_one_ready", {31'd0, f_ready}, 32'd1);
    f_pc = 32'h4; f_insn = 32'h00100093;
    @(negedge clock);
    chk("bp_two_ready", {31'd0, f_ready}, 32'd0);
    chk("bp_two_pc", d_pc, 32'h0);
    f_pc = 32'h8; f_insn = 32'h00200113;
    @(negedge clock);
    chk("bp_hold_pc", d_pc, 32'h0);
    d_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    f_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("bp_count", 32'(dlog.size()), 32'd3);
    if (dlog.size() == 3) begin
      chk("bp_order0", dlog[0], 32'h0);
      chk("bp_order1", dlog[1], 32'h4);
      chk("bp_order2", dlog[2], 32'h8);
    end

    // Full throughput.
    beats = 0; rdy_hi = 0;
    f_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_pc = 32'h100 + 32'(i * 4); f_insn = 32'h00000013 | (32'(i) << 20);
      @(negedge clock);
      if (d_valid) beats++;
      if (f_ready) rdy_hi++;
    end
    f_valid = 1'b0;
    chk("tput_beats", 32'(beats), 32'd8);
    chk("tput_ready", 32'(rdy_hi), 32'd8);
    @(negedge clock);

    // Flush while TWO with a same-cycle input.
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h200; f_insn = 32'h00000013;
    @(negedge clock);
    f_pc = 32'h204;
    @(negedge clock);
    chk("fl_two_ready", {31'd0, f_ready}, 32'd0);
    f_pc = 32'h208; flush = 1'b1;
    @(negedge clock);
    chk("fl_valid", {31'd0, d_valid}, 32'd0);
    chk("fl_ready", {31'd0, f_ready}, 32'd1);
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("fl_absent", {31'd0, d_valid}, 32'd0);

    // Illegal words still flow.
    for (int i = 0; i < 2; i++) begin
      f_valid = 1'b1; f_pc = 32'h300 + 32'(i * 4); f_insn = ill_insn[i];
      @(negedge clock);
      chk("ill_valid", {31'd0, d_valid}, 32'd1);
      chk("ill_flag", {31'd0, d_illegal}, 32'd1);
      chk("ill_imm", d_imm, 32'd0);
    end
    f_valid = 1'b0;
    @(negedge clock);

    // Reset mid-stream.
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h400; f_insn = 32'h00500093;
    @(negedge clock);
    f_pc = 32'h404; reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", {31'd0, d_valid}, 32'd0);
    chk("mid_rst_pc", d_pc, RESET_PC);
    reset = 1'b0; f_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid_rst_ready", {31'd0, f_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
